// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    // Canonical NOP (addi x0, x0, 0) presented to decode when the buffer is empty.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Fetch address advance per instruction word.
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Buffer entry layout: {pc, ir}.
    localparam int ENTRY_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_FAULT   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, ir} pairs between memory and decode.
// Flush wins over push/pop; a pop on an empty buffer is ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = ENTRY_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    // Storage array; contents are only meaningful where count says so, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and
// buffers returned words for decode. Redirects flush the buffer and drop any
// in-flight word.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no request; waits for buffer space
//   BUSY     | request at fetch_pc outstanding; ack pushes the word
//   DISCARD  | redirected mid-request; wait for the stale ack, drop it
//   FAULT    | bus error or misaligned target; waits for an aligned redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        ir_valid_o,
    input  logic        ir_ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  disc_addr_q, disc_addr_d;
    logic         disc_fault_q, disc_fault_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic               push;
    logic               pop;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               misaligned;
    logic [CW:0]        occ_after;

    assign misaligned = (redirect_pc_i[1:0] != 2'b00);
    assign pop        = ir_valid_o && ir_ready_i && !redirect_i;

    // Occupancy after this cycle when a word is pushed; decides whether to keep fetching.
    assign occ_after  = {1'b0, fifo_count} + (CW+1)'(1) - {{CW{1'b0}}, pop};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({fetch_pc_q, imem_rdata_i}),
        .count (fifo_count),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ir_valid_o = !fifo_empty;
    assign ir_o       = fifo_empty ? NOP_INSN : fifo_head[31:0];
    assign pc_o       = fifo_empty ? 32'h0    : fifo_head[63:32];
    assign fault_o    = fault_q;
    assign fault_pc_o = fault_pc_q;

    // State, PC and fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            disc_addr_q  <= RESET_PC;
            disc_fault_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_pc_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            disc_addr_q  <= disc_addr_d;
            disc_fault_q <= disc_fault_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    // Next-state, PC update, push and memory request outputs.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        disc_addr_d  = disc_addr_q;
        disc_fault_d = disc_fault_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        push         = 1'b0;
        imem_req_o   = (state_q == ST_BUSY) || (state_q == ST_DISCARD);
        // DISCARD must keep presenting the stale address until its ack arrives.
        imem_addr_o  = (state_q == ST_DISCARD) ? disc_addr_q : fetch_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    if (misaligned) begin
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc_i;
                        state_d    = ST_FAULT;
                    end else begin
                        state_d    = ST_BUSY;
                    end
                end else if (!fifo_full) begin
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    if (misaligned) begin
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc_i;
                    end
                    if (imem_ack_i) begin
                        state_d = misaligned ? ST_FAULT : ST_BUSY;
                    end else begin
                        state_d      = ST_DISCARD;
                        disc_addr_d  = fetch_pc_q;
                        disc_fault_d = misaligned;
                    end
                end else if (imem_ack_i) begin
                    if (imem_err_i) begin
                        fault_d    = 1'b1;
                        fault_pc_d = fetch_pc_q;
                        state_d    = ST_FAULT;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        state_d    = (occ_after < (CW+1)'(FIFO_DEPTH)) ? ST_BUSY : ST_IDLE;
                    end
                end
            end

            ST_DISCARD: begin
                if (redirect_i) begin
                    fetch_pc_d   = redirect_pc_i;
                    fault_d      = misaligned;
                    disc_fault_d = misaligned;
                    if (misaligned) begin
                        fault_pc_d = redirect_pc_i;
                    end
                end
                if (imem_ack_i) begin
                    if (redirect_i ? misaligned : disc_fault_q) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_BUSY;
                    end
                    disc_fault_d = 1'b0;
                end
            end

            ST_FAULT: begin
                if (redirect_i) begin
                    if (misaligned) begin
                        fault_pc_d = redirect_pc_i;
                    end else begin
                        fault_d    = 1'b0;
                        fetch_pc_d = redirect_pc_i;
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory whose
// ack latency and error address are set per scenario.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        ir_valid_o;
    logic        ir_ready_i;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat      = 0;
    int          wcnt     = 0;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .ir_valid_o    (ir_valid_o),
        .ir_ready_i    (ir_ready_i),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory model: ack after 'lat' wait cycles of a held request.
    assign imem_ack_i   = imem_req_o && (wcnt >= lat);
    assign imem_err_i   = imem_ack_i && err_en && (imem_addr_o == err_addr);
    assign imem_rdata_i = mem_word(imem_addr_o);

    always @(posedge clk) begin
        if (!imem_req_o || imem_ack_i) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!ir_valid_o && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'h0, ir_valid_o}, 32'h1);
    endtask

    task automatic wait_req_low(input string tag, input int budget);
        int n = 0;
        while (imem_req_o && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'h0, imem_req_o}, 32'h0);
    endtask

    task automatic wait_fault(input string tag, input int budget);
        int n = 0;
        while (!fault_o && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'h0, fault_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ir_ready_i    = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        reset         = 1'b0;

        // Reset values
        step();
        chk("rst_req",     {31'h0, imem_req_o}, 32'h0);
        chk("rst_addr",    imem_addr_o,         32'h0);
        chk("rst_valid",   {31'h0, ir_valid_o}, 32'h0);
        chk("rst_ir",      ir_o,                32'h0000_0013);
        chk("rst_pc",      pc_o,                32'h0);
        chk("rst_fault",   {31'h0, fault_o},    32'h0);
        chk("rst_faultpc", fault_pc_o,          32'h0);

        // Zero-wait streaming
        lat = 0;
        apply_reset();
        step();
        chk("s1_valid_e1", {31'h0, ir_valid_o}, 32'h0);
        chk("s1_req_e1",   {31'h0, imem_req_o}, 32'h1);
        chk("s1_addr_e1",  imem_addr_o,         32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("s1_valid", {31'h0, ir_valid_o}, 32'h1);
            chk("s1_pc",    pc_o,                32'(4 * k));
            chk("s1_ir",    ir_o,                mem_word(32'(4 * k)));
            step();
        end

        // Back-pressure fills the buffer then stops issuing
        ir_ready_i = 1'b0;
        apply_reset();
        step();
        step();
        chk("s2_pc_first", pc_o,                32'h0);
        chk("s2_req_busy", {31'h0, imem_req_o}, 32'h1);
        chk("s2_addr_4",   imem_addr_o,         32'h4);
        step();
        chk("s2_req_idle", {31'h0, imem_req_o}, 32'h0);
        chk("s2_pc_hold",  pc_o,                32'h0);
        step();
        chk("s2_req_idle2", {31'h0, imem_req_o}, 32'h0);
        ir_ready_i = 1'b1;
        step();
        chk("s2_pc_4",      pc_o,                32'h4);
        chk("s2_req_idle3", {31'h0, imem_req_o}, 32'h0);
        step();
        chk("s2_empty",     {31'h0, ir_valid_o}, 32'h0);
        chk("s2_req_res",   {31'h0, imem_req_o}, 32'h1);
        chk("s2_addr_8",    imem_addr_o,         32'h8);

        // Redirect during a 3-cycle-latency request
        lat = 2;
        apply_reset();
        step();
        chk("s3_req",  {31'h0, imem_req_o}, 32'h1);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        chk("s3_disc_req",  {31'h0, imem_req_o}, 32'h1);
        chk("s3_disc_addr", imem_addr_o,         32'h0);
        chk("s3_disc_vld",  {31'h0, ir_valid_o}, 32'h0);
        step();
        chk("s3_new_addr",  imem_addr_o,         32'h100);
        chk("s3_new_vld",   {31'h0, ir_valid_o}, 32'h0);
        wait_valid("s3_wait_valid", 12);
        chk("s3_pc",        pc_o,                32'h100);
        chk("s3_ir",        ir_o,                mem_word(32'h100));

        // Redirect coincident with ack and pop
        lat = 0;
        apply_reset();
        step();
        step();
        chk("s4_pre_pc", pc_o, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        chk("s4_flushed", {31'h0, ir_valid_o}, 32'h0);
        chk("s4_addr",    imem_addr_o,         32'h200);
        step();
        chk("s4_pc",      pc_o,                32'h200);

        // Bus error at 0x8, recovery through redirect
        err_en   = 1'b1;
        err_addr = 32'h8;
        apply_reset();
        wait_fault("s5_wait_fault", 12);
        chk("s5_fault_pc", fault_pc_o,          32'h8);
        chk("s5_req_low",  {31'h0, imem_req_o}, 32'h0);
        step();
        step();
        chk("s5_req_hold", {31'h0, imem_req_o}, 32'h0);
        chk("s5_sticky",   {31'h0, fault_o},    32'h1);
        err_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        chk("s5_cleared",  {31'h0, fault_o},    32'h0);
        step();
        chk("s5_req_res",  {31'h0, imem_req_o}, 32'h1);
        chk("s5_addr_res", imem_addr_o,         32'h40);
        step();
        chk("s5_pc_res",   pc_o,                32'h40);

        // Reset mid-request, then misaligned redirect
        lat = 3;
        apply_reset();
        step();
        chk("s6_req_pre", {31'h0, imem_req_o}, 32'h1);
        reset = 1'b0;
        #1;
        chk("s6_req_rst",  {31'h0, imem_req_o}, 32'h0);
        chk("s6_addr_rst", imem_addr_o,         32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("s6_req_busy", {31'h0, imem_req_o}, 32'h1);
        chk("s6_addr",     imem_addr_o,         32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        step();
        redirect_i = 1'b0;
        chk("s6_fault",     {31'h0, fault_o},    32'h1);
        chk("s6_fault_pc",  fault_pc_o,          32'h102);
        chk("s6_disc_req",  {31'h0, imem_req_o}, 32'h1);
        chk("s6_disc_addr", imem_addr_o,         32'h0);
        wait_req_low("s6_wait_drop", 12);
        chk("s6_vld",       {31'h0, ir_valid_o}, 32'h0);
        step();
        chk("s6_req_hold",  {31'h0, imem_req_o}, 32'h0);
        chk("s6_fault_hld", {31'h0, fault_o},    32'h1);

        // PC wraps past 0xFFFF_FFFC without faulting
        lat = 0;
        apply_reset();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        chk("s7_pc_top",  pc_o,             32'hFFFF_FFFC);
        step();
        chk("s7_pc_wrap", pc_o,             32'h0);
        chk("s7_ir_wrap", ir_o,             mem_word(32'h0));
        chk("s7_nofault", {31'h0, fault_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
